// File: rtl/debug_pkg.sv
// Shared definitions for the debug-unit host receive path.
package debug_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    // Receive FSM states of the UART core.
    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_BREAK = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: input synchroniser, 16x oversampling tick, frame FSM.
// Emits the received byte with a one-cycle valid pulse, or a one-cycle
// frame-error pulse when the stop bit is sampled low.
module uart_rx_core
    import debug_pkg::*;
#(
    parameter int BYTE     = 8,
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            rx_i,
    output logic [BYTE-1:0] byte_o,
    output logic            byte_valid_o,
    output logic            frame_err_o
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W   = (BYTE > 1) ? $clog2(BYTE) : 1;

    logic             rx_meta_q, rx_sync_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;

    rx_state_e        state_q, state_d;
    logic [3:0]       tcnt_q, tcnt_d;
    logic [BIT_W-1:0] bidx_q, bidx_d;
    logic [BYTE-1:0]  shift_q, shift_d;
    logic [BYTE-1:0]  byte_q, byte_d;
    logic             vld_q, vld_d;
    logic             ferr_q, ferr_d;

    // Two-flop synchroniser, preset to the idle line level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Free-running oversampling divider; tick on wrap.
    always_comb begin
        tick  = (div_q == DIV_W'(DIV - 1));
        div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    // Frame FSM next state: IDLE reacts every clock, other states on ticks.
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        bidx_d  = bidx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        vld_d   = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    state_d = RX_START;
                    tcnt_d  = '0;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (tcnt_q == 4'd7) begin
                        tcnt_d = '0;
                        bidx_d = '0;
                        // A start bit that is gone by mid-bit was a glitch.
                        state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (tcnt_q == 4'd15) begin
                        tcnt_d  = '0;
                        shift_d = {rx_sync_q, shift_q[BYTE-1:1]};
                        if (bidx_q == BIT_W'(BYTE - 1)) begin
                            state_d = RX_STOP;
                        end else begin
                            bidx_d = bidx_q + BIT_W'(1);
                        end
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    if (tcnt_q == 4'd15) begin
                        tcnt_d = '0;
                        if (rx_sync_q) begin
                            byte_d  = shift_q;
                            vld_d   = 1'b1;
                            state_d = RX_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = RX_BREAK;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end
            end
            RX_BREAK: begin
                if (rx_sync_q) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Divider and FSM registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q   <= '0;
            state_q <= RX_IDLE;
            tcnt_q  <= '0;
            bidx_q  <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            vld_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            div_q   <= div_d;
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            bidx_q  <= bidx_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            vld_q   <= vld_d;
            ferr_q  <= ferr_d;
        end
    end

    assign byte_o       = byte_q;
    assign byte_valid_o = vld_q;
    assign frame_err_o  = ferr_q;

endmodule

// File: rtl/debug_host_rx.sv
// Host-side receive end of the debug UART link: bytes are packed little-endian
// into 32-bit words and queued in a first-word-fall-through FIFO.
module debug_host_rx
    import debug_pkg::*;
#(
    parameter int BYTE     = 8,
    parameter int ADDR     = 5,
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_rx,
    input  logic              i_clear,
    input  logic              i_rd_en,
    output logic [WORD_W-1:0] o_rd_data,
    output logic              o_empty,
    output logic              o_full,
    output logic [ADDR:0]     o_count,
    output logic [BYTE-1:0]   o_byte,
    output logic              o_byte_valid,
    output logic              o_frame_err,
    output logic              o_overflow
);

    localparam int DEPTH = 2 ** ADDR;
    localparam int CNT_W = ADDR + 1;
    localparam int KW    = $clog2(BYTES_PER_WORD);

    logic [BYTE-1:0]   rx_byte;
    logic              rx_vld, rx_ferr;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [ADDR-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [KW-1:0]     k_q, k_d;
    logic [WORD_W-1:0] word_q, word_d, asm_word;
    logic              ovf_q, ovf_d, ferr_q, ferr_d;
    logic              push, pop, empty, full, do_write;

    uart_rx_core #(
        .BYTE     (BYTE),
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_core (
        .clk_i        (i_clock),
        .rst_ni       (i_reset_n),
        .rx_i         (i_rx),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_vld),
        .frame_err_o  (rx_ferr)
    );

    // Word assembly, FIFO bookkeeping and sticky flags; clear wins over all.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CNT_W'(DEPTH));
        asm_word = word_q;
        asm_word[k_q*BYTE +: BYTE] = rx_byte;
        push     = rx_vld && (k_q == KW'(BYTES_PER_WORD - 1));
        pop      = i_rd_en && !empty;
        // A pop in the same cycle frees the slot a full FIFO needs.
        do_write = push && (!full || pop);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        k_d      = k_q;
        word_d   = word_q;
        ovf_d    = ovf_q;
        ferr_d   = ferr_q;
        if (i_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            k_d      = '0;
            word_d   = '0;
            ovf_d    = 1'b0;
            ferr_d   = 1'b0;
        end else begin
            if (rx_vld) begin
                word_d = asm_word;
                k_d    = k_q + KW'(1);
            end
            if (rx_ferr) ferr_d = 1'b1;
            if (push && !do_write) ovf_d = 1'b1;
            if (do_write) wr_ptr_d = wr_ptr_q + ADDR'(1);
            if (pop) rd_ptr_d = rd_ptr_q + ADDR'(1);
            count_d = count_q + CNT_W'(do_write) - CNT_W'(pop);
        end
    end

    // Control registers.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            k_q      <= '0;
            word_q   <= '0;
            ovf_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            k_q      <= k_d;
            word_q   <= word_d;
            ovf_q    <= ovf_d;
            ferr_q   <= ferr_d;
        end
    end

    // FIFO storage; contents need no reset since reads are gated by empty.
    always_ff @(posedge i_clock) begin
        if (!i_clear && do_write) mem_q[wr_ptr_q] <= asm_word;
    end

    assign o_rd_data    = empty ? '0 : mem_q[rd_ptr_q];
    assign o_empty      = empty;
    assign o_full       = full;
    assign o_count      = count_q;
    assign o_byte       = rx_byte;
    assign o_byte_valid = rx_vld;
    assign o_frame_err  = ferr_q;
    assign o_overflow   = ovf_q;

endmodule
